// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: access-mode encodings and the
// masked-merge helper used by every writable cell.
package register_bank_pkg;

    // Access modes, two bits per register in ACCESS_MODES.
    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;
    localparam logic [1:0] MODE_RC  = 2'd3;

    // Widest register the merge helper handles; narrower callers zero-extend.
    localparam int unsigned MAX_WIDTH = 64;

    // Bits with mask = 1 take data, the rest keep cur.
    function automatic logic [MAX_WIDTH-1:0] masked_merge(
        input logic [MAX_WIDTH-1:0] cur,
        input logic [MAX_WIDTH-1:0] data,
        input logic [MAX_WIDTH-1:0] mask
    );
        return (cur & ~mask) | (data & mask);
    endfunction

    // Software may only modify RW and W1C registers.
    function automatic logic sw_writable(input logic [1:0] mode);
        return (mode == MODE_RW) || (mode == MODE_W1C);
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One register of the bank.
// Ports:
//   clk, rst_n        clock, async active-low reset (loads RESET_VALUE)
//   sw_we             software write addressed to this register
//   wr_data, wr_mask  software write data and per-bit enable
//   rd_clr            accepted in-range read of this register (clears RC)
//   hw_update         hardware strobe, hw_value its data
//   value             current contents (flop output)
//   changed           pulses the cycle after the contents changed
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [1:0]       MODE        = MODE_RW,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             rd_clr,
    input  logic             hw_update,
    input  logic [WIDTH-1:0] hw_value,
    output logic [WIDTH-1:0] value,
    output logic             changed
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] w1c_clr;
    logic             changed_q;

    always_comb begin
        value_d = value_q;
        w1c_clr = '0;
        case (MODE)
            // Software write wins outright, even on masked-off bits.
            MODE_RW: begin
                if (sw_we) begin
                    value_d = WIDTH'(masked_merge(MAX_WIDTH'(value_q), MAX_WIDTH'(wr_data),
                                                  MAX_WIDTH'(wr_mask)));
                end else if (hw_update) begin
                    value_d = hw_value;
                end
            end
            MODE_RO: begin
                if (hw_update) value_d = hw_value;
            end
            // Hardware set beats a simultaneous software clear.
            MODE_W1C: begin
                if (sw_we) w1c_clr = wr_data & wr_mask;
                value_d = (value_q & ~w1c_clr) | (hw_update ? hw_value : '0);
            end
            // A read clears; bits set by hardware in the same cycle survive.
            MODE_RC: begin
                if (rd_clr) begin
                    value_d = hw_update ? hw_value : '0;
                end else if (hw_update) begin
                    value_d = value_q | hw_value;
                end
            end
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= RESET_VALUE;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= (value_d != value_q);
        end
    end

    assign value   = value_q;
    assign changed = changed_q;

endmodule

// File: rtl/register_bank.sv
// Addressable CSR bank of NUM_REGS registers with per-register access modes.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   wr_en, wr_addr, wr_data, wr_mask  masked software write
//   rd_en, rd_addr                    software read request
//   rd_data, rd_valid                 registered read response (1-cycle latency)
//   err                               registered pulse for a bad access
//   hw_update, hw_value               per-register hardware update
//   curr_value                        all register contents, flattened
//   changed                           per-register change pulse
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned                 WIDTH        = 32,
    parameter int unsigned                 NUM_REGS     = 8,
    parameter int unsigned                 ADDR_W       = 3,
    parameter logic [NUM_REGS*WIDTH-1:0]   RESET_VALUES = '0,
    parameter logic [NUM_REGS*2-1:0]       ACCESS_MODES = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH-1:0]          wr_mask,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      err,
    input  logic [NUM_REGS-1:0]       hw_update,
    input  logic [NUM_REGS*WIDTH-1:0] hw_value,
    output logic [NUM_REGS*WIDTH-1:0] curr_value,
    output logic [NUM_REGS-1:0]       changed
);

    // Decode over the full address space; unused slots read as 0 and are RO.
    localparam int unsigned NUM_SLOTS = 2 ** ADDR_W;

    logic [WIDTH-1:0] value_arr [NUM_SLOTS];
    logic [1:0]       mode_arr  [NUM_SLOTS];

    logic             wr_in_range, rd_in_range;
    logic             wr_err, rd_err;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q, err_q;

    assign wr_in_range = 32'(wr_addr) < NUM_REGS;
    assign rd_in_range = 32'(rd_addr) < NUM_REGS;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        if (i < NUM_REGS) begin : g_reg
            logic [WIDTH-1:0] cell_value;

            register_bank_cell #(
                .WIDTH       (WIDTH),
                .MODE        (ACCESS_MODES[2*i +: 2]),
                .RESET_VALUE (RESET_VALUES[i*WIDTH +: WIDTH])
            ) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .sw_we     (wr_en && wr_in_range && (wr_addr == ADDR_W'(i))),
                .wr_data   (wr_data),
                .wr_mask   (wr_mask),
                .rd_clr    (rd_en && rd_in_range && (rd_addr == ADDR_W'(i))),
                .hw_update (hw_update[i]),
                .hw_value  (hw_value[i*WIDTH +: WIDTH]),
                .value     (cell_value),
                .changed   (changed[i])
            );

            assign value_arr[i]                    = cell_value;
            assign mode_arr[i]                     = ACCESS_MODES[2*i +: 2];
            assign curr_value[i*WIDTH +: WIDTH]    = cell_value;
        end else begin : g_empty
            assign value_arr[i] = '0;
            assign mode_arr[i]  = MODE_RO;
        end
    end

    // Writes to RO/RC registers are dropped by the cell itself; flag them here.
    assign wr_err = wr_en && (!wr_in_range || !sw_writable(mode_arr[wr_addr]));
    assign rd_err = rd_en && !rd_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            err_q      <= wr_err || rd_err;
            if (rd_en) rd_data_q <= rd_in_range ? value_arr[rd_addr] : '0;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NUM_REGS registers, each WIDTH bits, with a per-register access mode and a reset value.
- Software side: masked write port plus a read port with 1-cycle latency.
- Hardware side: per-register update strobe and value.
- Generalises the single update/default register into an addressable CSR block; sits between the bus adapter and datapath logic.

Parameters:
- WIDTH, 32, bits per register.
- NUM_REGS, 8, number of registers (2..256).
- ADDR_W, 3, address width; 2**ADDR_W >= NUM_REGS.
- RESET_VALUES, 0, flattened NUM_REGS*WIDTH reset vector; reg i uses slice [i*WIDTH +: WIDTH].
- ACCESS_MODES, 0, flattened NUM_REGS*2 mode vector: 0=RW, 1=RO, 2=W1C, 3=RC (clear-on-read).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  software write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- wr_mask  in  WIDTH  per-bit write enable.
- rd_en  in  1  software read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  WIDTH  read data, registered.
- rd_valid  out  1  pulses 1 cycle after an accepted rd_en.
- err  out  1  registered error pulse for a bad access.
- hw_update  in  NUM_REGS  per-register hardware strobe.
- hw_value  in  NUM_REGS*WIDTH  per-register hardware data.
- curr_value  out  NUM_REGS*WIDTH  all register contents, flop outputs.
- changed  out  NUM_REGS  1-cycle pulse the cycle after register i's value changed.

Behaviour:
- Reset (async assert, sync release):
  - curr_value = RESET_VALUES.
  - rd_data = 0, rd_valid = 0, err = 0, changed = 0.
- Address decode: addr >= NUM_REGS is out of range.
- Write, taking effect on the edge after wr_en:
  - RW: next = (cur & ~wr_mask) | (wr_data & wr_mask).
  - RO: write ignored.
  - W1C: clear bits where wr_data & wr_mask = 1.
  - RC: write ignored.
- Hardware update when hw_update[i] = 1:
  - RW, RO: load hw_value.
  - W1C, RC: OR hw_value into cur (sticky set).
- Priority, same cycle, same register:
  - RW: software write beats hw_update, fully, including bits with wr_mask = 0.
  - W1C: set wins; next = (cur & ~(wr_data & wr_mask)) | hw_value.
- Read:
  - rd_en in cycle N gives rd_data = pre-edge cur and rd_valid = 1 in cycle N+1.
  - rd_data holds its value when rd_valid = 0.
- RC side effect:
  - An accepted in-range read clears the register at the same edge.
  - Bits set by hw_update in that same cycle survive: next = hw_update ? hw_value : 0.
- Simultaneous rd_en and wr_en to the same address: read returns the old value; the write still applies.
- Error cases, each giving err = 1 in cycle N+1:
  - Out-of-range write: no state change.
  - Write to an RO or RC register: no state change.
  - Out-of-range read: rd_valid = 1, rd_data = 0.
  - Read and write errors in the same cycle produce a single err pulse.
- changed[i] = registered (next_i != cur_i); it is never asserted for a write that leaves the value identical.
- Reset asserted mid-operation: all outputs return to reset values immediately; any pending read response is dropped.
- Every access is single-cycle with no backpressure; the port is accepted every cycle.

Decomposition:
- Shared package register_bank_pkg:
  - access-mode localparams MODE_RW/MODE_RO/MODE_W1C/MODE_RC.
  - helper function for the masked-merge next-value calculation.
- One natural sub-module, register_bank_cell:
  - a single register: mode, reset value, write/clear/hw inputs, value and changed outputs.
  - instantiated NUM_REGS times via generate.
- The top level holds address decode, the read mux/pipeline and the error logic.

Test Plan:
- Reset values: RESET_VALUES reg0 = 0xDEADBEEF; release reset.
  - curr_value[0] = 0xDEADBEEF, all others 0.
  - rd_valid = 0, err = 0.
- RW masked write: reg0 RW = 0x0; write 0xFFFF_FFFF with mask 0x0000_FF00.
  - reg0 = 0x0000_FF00; changed[0] pulses once.
  - Read returns 0x0000_FF00 one cycle later.
- W1C set-wins: reg2 W1C = 0x0F; write 0x03, mask 0xFFFFFFFF, with hw_update[2] and hw_value = 0x01 in the same cycle.
  - reg2 = 0x0D.
- RC read-clear: reg3 RC = 0xA5; read it.
  - rd_data = 0xA5, then reg3 = 0.
  - Repeat the read with hw_update[3], hw_value = 0x10 in the same cycle: rd_data = 0, then reg3 = 0x10.
- Errors, with NUM_REGS = 6:
  - Write to addr 7: no change anywhere, err = 1 next cycle.
  - Read of addr 6: rd_valid = 1, rd_data = 0, err = 1.
  - Write to RO reg1: reg1 unchanged, err = 1.
- Read/write collision and reset: reg0 = 0x11; read and write 0x22 to addr 0 in the same cycle.
  - rd_data = 0x11, reg0 = 0x22.
  - Assert rst_n low on the next cycle: rd_valid drops to 0 and reg0 returns to its reset value asynchronously.
